// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe
// Purpose  : Parametrised, elastic, pipelined shift unit for the CPU datapath.
//            Performs SLL / SRL / SRA and, when SHIFT_PIPE_ROR_EN is defined,
//            rotate-right. The LOG2W-level shift network is distributed over
//            STAGES register stages; a tag rides along with each operation.
// Macro    : SHIFT_PIPE_ROR_EN - op 2'b11 rotates right when defined,
//            otherwise op 2'b11 behaves as SRL and no rotate logic is built.
// Ports    : clk, rst_n (sync, active-low), flush (sync pipeline kill)
//            in_valid/in_ready/in_op/in_data/in_shamt/in_tag  - request side
//            out_valid/out_ready/out_data/out_tag              - result side
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe #(
   parameter int WIDTH  = 32,
   parameter int LOG2W  = $clog2(WIDTH),
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LOG2W-1:0] in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [1:0] c_op_sll = 2'b00;
   localparam logic [1:0] c_op_sra = 2'b10;
`ifdef SHIFT_PIPE_ROR_EN
   localparam logic [1:0] c_op_ror = 2'b11;
`endif

   // Per-stage pipeline registers
   logic             r_vld   [STAGES];
   logic [1:0]       r_op    [STAGES];
   logic [WIDTH-1:0] r_data  [STAGES];
   logic [LOG2W-1:0] r_shamt [STAGES];
   logic             r_sign  [STAGES];
   logic [TAG_W-1:0] r_tag   [STAGES];

   // Per-stage inputs (from the request port or the previous register)
   logic             w_vin      [STAGES];
   logic [1:0]       w_st_op    [STAGES];
   logic [WIDTH-1:0] w_st_data  [STAGES];
   logic [LOG2W-1:0] w_st_shamt [STAGES];
   logic             w_st_sign  [STAGES];
   logic [TAG_W-1:0] w_st_tag   [STAGES];
   logic [WIDTH-1:0] w_st_res   [STAGES];

   logic             w_load [STAGES];
   logic             w_in_ready;
   logic [WIDTH-1:0] w_acc;

   // One network level: shift by 2^lvl according to op. SRA fills from the
   // sign bit captured at acceptance, so later levels stay correctly filled.
   function automatic logic [WIDTH-1:0] f_level(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input logic             sgn,
      input int               lvl
   );
      int amt;
      logic [WIDTH-1:0] hi;
      amt = 1 << lvl;
      hi  = ~({WIDTH{1'b1}} >> amt);
      case (op)
         c_op_sll: f_level = d << amt;
         c_op_sra: f_level = (d >> amt) | (sgn ? hi : '0);
`ifdef SHIFT_PIPE_ROR_EN
         c_op_ror: f_level = (d >> amt) | (d << (WIDTH - amt));
`endif
         default:  f_level = d >> amt;
      endcase
   endfunction

   // Stage input selection
   for (genvar s = 0; s < STAGES; s++) begin : g_src
      if (s == 0) begin : g_head
         assign w_vin[s]      = in_valid && w_in_ready;
         assign w_st_op[s]    = in_op;
         assign w_st_data[s]  = in_data;
         assign w_st_shamt[s] = in_shamt;
         assign w_st_sign[s]  = in_data[WIDTH-1];
         assign w_st_tag[s]   = in_tag;
      end else begin : g_body
         assign w_vin[s]      = r_vld[s-1];
         assign w_st_op[s]    = r_op[s-1];
         assign w_st_data[s]  = r_data[s-1];
         assign w_st_shamt[s] = r_shamt[s-1];
         assign w_st_sign[s]  = r_sign[s-1];
         assign w_st_tag[s]   = r_tag[s-1];
      end
   end

   // Ready ripples backwards: a stage may load when it is empty or when its
   // downstream can take its current content. Walking from the output end
   // keeps this a plain chain with no feedback.
   always_comb begin
      logic v_rdy;
      v_rdy = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         w_load[s] = !r_vld[s] || v_rdy;
         v_rdy     = w_load[s];
      end
   end

   assign w_in_ready = rst_n && !flush && w_load[0];
   assign in_ready   = w_in_ready;

   // Shift network: level i lives in stage floor(i*STAGES/LOG2W)
   always_comb begin
      w_acc = '0;
      for (int s = 0; s < STAGES; s++) begin
         w_acc = w_st_data[s];
         for (int i = 0; i < LOG2W; i++) begin
            if (((i * STAGES) / LOG2W == s) && w_st_shamt[s][i]) begin
               w_acc = f_level(w_acc, w_st_op[s], w_st_sign[s], i);
            end
         end
         w_st_res[s] = w_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            r_vld[s]   <= 1'b0;
            r_op[s]    <= '0;
            r_data[s]  <= '0;
            r_shamt[s] <= '0;
            r_sign[s]  <= 1'b0;
            r_tag[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (flush) begin
               r_vld[s] <= 1'b0;
            end else if (w_load[s]) begin
               r_vld[s] <= w_vin[s];
            end
            // Payload only moves with a valid entry, so a held result stays put
            if (w_load[s] && w_vin[s]) begin
               r_op[s]    <= w_st_op[s];
               r_data[s]  <= w_st_res[s];
               r_shamt[s] <= w_st_shamt[s];
               r_sign[s]  <= w_st_sign[s];
               r_tag[s]   <= w_st_tag[s];
            end
         end
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign out_data  = r_data[STAGES-1];
   assign out_tag   = r_tag[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_pipe
// Purpose  : Self-checking bench for shift_pipe (WIDTH=32, STAGES=2). Uses a
//            directed vector table, hand sequences for backpressure, flush
//            and reset, and random traffic against a reference model.
// Macro    : SHIFT_PIPE_ROR_EN selects rotate or SRL expectations for op 11.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

   localparam int W  = 32;
   localparam int LW = 5;
   localparam int TW = 5;
   localparam int NV = 14;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]    in_op;
   logic [W-1:0]  in_data, out_data;
   logic [LW-1:0] in_shamt;
   logic [TW-1:0] in_tag, out_tag;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]    op;
      logic [W-1:0]  data;
      logic [LW-1:0] sh;
      logic [TW-1:0] tag;
      logic [W-1:0]  exp;
   } vec_t;

   typedef struct {
      logic [1:0]    op;
      logic [W-1:0]  data;
      logic [LW-1:0] sh;
      logic [TW-1:0] tag;
   } req_t;

   typedef struct {
      logic [W-1:0]  data;
      logic [TW-1:0] tag;
   } res_t;

   vec_t vt [NV];
   req_t stim_q [$];
   res_t exp_q  [$];

   shift_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   // Reference model from the shift definitions themselves
   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                          input logic [LW-1:0] sh);
      logic [2*W-1:0] dd;
      dd = {d, d} >> sh;
      case (op)
         2'd0:    return d << sh;
         2'd1:    return d >> sh;
         2'd2:    return W'($signed(d) >>> sh);
`ifdef SHIFT_PIPE_ROR_EN
         default: return dd[W-1:0];
`else
         default: return d >> sh;
`endif
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle of streaming traffic; starts and ends 1 time unit after posedge
   task automatic run_cycle(input logic ordy);
      res_t e;
      out_ready = ordy;
      if (stim_q.size() > 0) begin
         in_valid = 1'b1;
         in_op    = stim_q[0].op;
         in_data  = stim_q[0].data;
         in_shamt = stim_q[0].sh;
         in_tag   = stim_q[0].tag;
      end else begin
         in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got data %0h tag %0h, expected none", out_data, out_tag);
         end else begin
            check("pipe_data", 64'(out_data), 64'(exp_q[0].data));
            check("pipe_tag", 64'(out_tag), 64'(exp_q[0].tag));
            void'(exp_q.pop_front());
         end
      end
      if (in_valid && in_ready) begin
         e.data = model(stim_q[0].op, stim_q[0].data, stim_q[0].sh);
         e.tag  = stim_q[0].tag;
         exp_q.push_back(e);
         void'(stim_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic add_req(input logic [1:0] op, input logic [W-1:0] d,
                          input logic [LW-1:0] sh, input logic [TW-1:0] tag);
      req_t r;
      r.op = op; r.data = d; r.sh = sh; r.tag = tag;
      stim_q.push_back(r);
   endtask

   task automatic drain();
      for (int c = 0; c < 50 && (stim_q.size() > 0 || exp_q.size() > 0); c++) run_cycle(1'b1);
      check("drained", 64'(stim_q.size() + exp_q.size()), 64'd0);
   endtask

   initial begin
      int lat;
      vt[0]  = '{2'd1, 32'h80000000, 5'd31, 5'd7,  32'h00000001};
      vt[1]  = '{2'd2, 32'h80000000, 5'd4,  5'd1,  32'hF8000000};
      vt[2]  = '{2'd2, 32'h7FFFFFF0, 5'd4,  5'd2,  32'h07FFFFFF};
      vt[3]  = '{2'd0, 32'h00000001, 5'd31, 5'd3,  32'h80000000};
      vt[4]  = '{2'd0, 32'hDEADBEEF, 5'd0,  5'd4,  32'hDEADBEEF};
      vt[5]  = '{2'd1, 32'hDEADBEEF, 5'd0,  5'd5,  32'hDEADBEEF};
      vt[6]  = '{2'd2, 32'hDEADBEEF, 5'd0,  5'd6,  32'hDEADBEEF};
      vt[7]  = '{2'd3, 32'hDEADBEEF, 5'd0,  5'd8,  32'hDEADBEEF};
      vt[8]  = '{2'd2, 32'hFFFFFFFF, 5'd31, 5'd9,  32'hFFFFFFFF};
      vt[9]  = '{2'd0, 32'hDEADBEEF, 5'd4,  5'd10, 32'hEADBEEF0};
      vt[10] = '{2'd1, 32'hDEADBEEF, 5'd8,  5'd11, 32'h00DEADBE};
      vt[11] = '{2'd2, 32'h80000001, 5'd1,  5'd12, 32'hC0000000};
`ifdef SHIFT_PIPE_ROR_EN
      vt[12] = '{2'd3, 32'h00000001, 5'd1,  5'd13, 32'h80000000};
      vt[13] = '{2'd3, 32'h12345678, 5'd8,  5'd31, 32'h78123456};
`else
      vt[12] = '{2'd3, 32'h00000001, 5'd1,  5'd13, 32'h00000000};
      vt[13] = '{2'd3, 32'h12345678, 5'd8,  5'd31, 32'h00123456};
`endif

      // Reset state
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_op = '0; in_data = '0; in_shamt = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1;

      // Directed vector table, one at a time, with latency check
      for (int k = 0; k < NV; k++) begin
         in_valid = 1'b1; in_op = vt[k].op; in_data = vt[k].data;
         in_shamt = vt[k].sh; in_tag = vt[k].tag; out_ready = 1'b1;
         #1;
         check("vec_in_ready", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check("vec_latency", 64'(lat), 64'd2);
         check("vec_data", 64'(out_data), 64'(vt[k].exp));
         check("vec_tag", 64'(out_tag), 64'(vt[k].tag));
         @(posedge clk);
         #1;
      end

      // Backpressure: four SLL of 1 with the consumer stalled for five cycles
      for (int k = 0; k < 4; k++) add_req(2'd0, 32'h1, LW'(k), TW'(k + 16));
      for (int c = 0; c < 5; c++) begin
         run_cycle(1'b0);
         if (c >= 2) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'h1);
         end
      end
      check("bp_occupancy", 64'(exp_q.size()), 64'd2);
      drain();

      // Flush with two entries in flight and a new request in the same cycle
      add_req(2'd1, 32'hAAAA0000, 5'd4, 5'd1);
      add_req(2'd1, 32'hBBBB0000, 5'd4, 5'd2);
      run_cycle(1'b0);
      run_cycle(1'b0);
      check("fl_inflight", 64'(exp_q.size()), 64'd2);
      flush = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_data = 32'h5; in_shamt = 5'd1;
      in_tag = 5'd9; out_ready = 1'b1;
      #1;
      check("fl_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      check("fl_out_valid", 64'(out_valid), 64'd0);
      exp_q.delete();
      for (int c = 0; c < 3; c++) begin
         run_cycle(1'b1);
         check("fl_idle", 64'(out_valid), 64'd0);
      end
      add_req(2'd1, 32'h000000F0, 5'd4, 5'd3);
      drain();

      // Reset with two entries in flight
      add_req(2'd0, 32'h12345678, 5'd4, 5'd5);
      add_req(2'd2, 32'h87654321, 5'd8, 5'd6);
      run_cycle(1'b0);
      run_cycle(1'b0);
      rst_n = 1'b0; in_valid = 1'b1;
      #1;
      check("rm_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1; in_valid = 1'b0;
      check("rm_out_valid", 64'(out_valid), 64'd0);
      check("rm_out_data", 64'(out_data), 64'd0);
      check("rm_out_tag", 64'(out_tag), 64'd0);
      exp_q.delete();
      for (int c = 0; c < 4; c++) begin
         run_cycle(1'b1);
         check("rm_idle", 64'(out_valid), 64'd0);
      end

      // Random traffic with random backpressure against the model
      for (int c = 0; c < 400; c++) begin
         if (stim_q.size() == 0 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0:       add_req(2'($urandom), $urandom, 5'd0, 5'($urandom));
               1:       add_req(2'($urandom), $urandom, 5'd31, 5'($urandom));
               default: add_req(2'($urandom), $urandom, 5'($urandom), 5'($urandom));
            endcase
         end
         run_cycle($urandom_range(0, 3) != 0);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined shift unit for the CPU datapath. Generalises the fixed 32-bit combinational logical-right shifter.
- Performs logical-left, logical-right and arithmetic-right shifts; rotate-right is optional.
- Data width is configurable. Pipeline depth is configurable. Input and output use valid/ready handshakes, and a tag is carried so writeback can match each result to its destination register.

Parameters:
- WIDTH, 32: operand/result width. Must be a power of two, 8..64.
- LOG2W, $clog2(WIDTH): shift-amount width. Derived; must not be overridden.
- STAGES, 2: number of register stages, range 1..LOG2W.
- TAG_W, 5: width of the sideband tag (destination register index).

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- flush, input, 1: synchronous pipeline kill (branch/exception).
- in_valid, input, 1: request present.
- in_ready, output, 1: request accepted this cycle when in_valid && in_ready.
- in_op, input, 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR (optional).
- in_data, input, WIDTH: operand to shift.
- in_shamt, input, LOG2W: shift amount. Caller extracts the field, e.g. instr[10:6] for WIDTH=32.
- in_tag, input, TAG_W: sideband, passed through unchanged.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer accepts the result when out_valid && out_ready.
- out_data, output, WIDTH: shifted result.
- out_tag, output, TAG_W: tag of out_data.

Behaviour:
- Shift network: LOG2W levels; level i shifts by 2^i when shamt[i]=1. Level i is placed in stage floor(i*STAGES/LOG2W), and each stage ends in a register.
- Each stage register holds: valid, op, partial data, remaining shamt bits, original sign bit, tag.
- Fill rules:
  - SLL fills 0s from the LSB side.
  - SRL fills 0s from the MSB side.
  - SRA fills with in_data[WIDTH-1] captured at acceptance.
- shamt=0 returns in_data unchanged for every op. shamt is LOG2W bits wide, so there is no overflow case.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure. Throughput is one result per cycle.
- Elastic flow: stage k loads when stage k is empty or stage k is advancing. The last stage advances on out_ready.
- in_ready = !flush && (stage0 empty || stage0 advancing). in_ready is combinational from out_ready and the valid bits; there is no combinational path from in_data.
- Backpressure: while out_valid && !out_ready, out_data and out_tag hold stable and no entry is lost or reordered. Maximum occupancy is STAGES entries.
- Ordering: strict FIFO.
- flush=1: all stage valid bits clear at the next edge and out_valid drops the following cycle. A request presented in the same cycle is not accepted. Flush beats acceptance and beats out_ready.
- Reset (rst_n=0 at an edge): all valid bits 0, data and tag registers 0. This gives out_valid=0, out_data=0, out_tag=0; in_ready=0 while rst_n=0.
- Reset mid-operation discards all in-flight entries. Reset has priority over flush and over the handshakes.
- No state machine beyond the per-stage valid bits. Unused op encodings do not exist (all 4 are defined).

Optional Feature:
- Macro: SHIFT_PIPE_ROR_EN.
- Defined: op 11 rotates in_data right by shamt; the bits shifted out re-enter at the MSB.
- Undefined: op 11 behaves exactly as SRL and the rotate datapath is not synthesised.

Test Plan:
- Latency and SRL: WIDTH=32, STAGES=2, out_ready=1. SRL 0x80000000 by 31 with tag 7 accepted at cycle t -> out_valid at t+2, out_data 0x00000001, out_tag 7.
- SRA and SLL: SRA 0x80000000 by 4 -> 0xF8000000. SRA 0x7FFFFFF0 by 4 -> 0x07FFFFFF. SLL 0x00000001 by 31 -> 0x80000000. Any op with shamt 0 on 0xDEADBEEF -> 0xDEADBEEF.
- Backpressure: 4 back-to-back SLL 0x1 by 0,1,2,3 with out_ready=0 for cycles 1..5 -> in_ready low once 2 entries are held, out_data stable. After release, outputs 0x1, 0x2, 0x4, 0x8 in order, none lost.
- Flush: 2 entries in flight and flush=1 together with a new in_valid -> the new request is not accepted and out_valid=0 the next cycle. The next request afterwards is processed normally.
- Reset mid-op: rst_n=0 for 1 cycle with 2 entries in flight -> out_valid=0, out_data=0, out_tag=0; nothing emerges later.
- Rotate: op 11, 0x00000001 by 1 -> 0x80000000 with SHIFT_PIPE_ROR_EN defined, and 0x00000000 without it.
